decode_queue: RTL and testbench



---
 rtl/decode_pkg.sv | 66 ++++++
 rtl/decode_queue_rv_decoder.sv | 147 ++++++++++++++
 rtl/decode_queue.sv | 78 +++++++
 tb/tb_decode_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I(+M) decode stage.
// Control codes select the execute operation; uop_t is the queued micro-op.
package decode_pkg;

    localparam int unsigned UOP_XLEN = 32;

    localparam logic [4:0] CTL_AND    = 5'd0;
    localparam logic [4:0] CTL_OR     = 5'd1;
    localparam logic [4:0] CTL_ADD    = 5'd2;
    localparam logic [4:0] CTL_XOR    = 5'd3;
    localparam logic [4:0] CTL_SLL    = 5'd4;
    localparam logic [4:0] CTL_SRL    = 5'd5;
    localparam logic [4:0] CTL_SUB    = 5'd6;
    localparam logic [4:0] CTL_SLT    = 5'd7;
    localparam logic [4:0] CTL_LUI    = 5'd10;
    localparam logic [4:0] CTL_SLTU   = 5'd13;
    localparam logic [4:0] CTL_SRA    = 5'd15;
    localparam logic [4:0] CTL_MUL    = 5'd16;
    localparam logic [4:0] CTL_MULH   = 5'd17;
    localparam logic [4:0] CTL_MULHSU = 5'd18;
    localparam logic [4:0] CTL_MULHU  = 5'd19;
    localparam logic [4:0] CTL_DIV    = 5'd20;
    localparam logic [4:0] CTL_DIVU   = 5'd21;
    localparam logic [4:0] CTL_REM    = 5'd22;
    localparam logic [4:0] CTL_REMU   = 5'd23;
    localparam logic [4:0] CTL_BEQ    = 5'd24;
    localparam logic [4:0] CTL_BNE    = 5'd25;
    localparam logic [4:0] CTL_BLT    = 5'd26;
    localparam logic [4:0] CTL_BGE    = 5'd27;
    localparam logic [4:0] CTL_BLTU   = 5'd28;
    localparam logic [4:0] CTL_BGEU   = 5'd29;
    localparam logic [4:0] CTL_ZERO   = 5'd31;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [UOP_XLEN-1:0] pc;
        logic [UOP_XLEN-1:0] imm;
        logic [4:0]          ctl;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                read_rs1;
        logic                read_rs2;
        logic                src_imm;
        logic                src_pc;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic                branch;
        logic                jump;
        logic                link;
        logic                illegal;
    } uop_t;

endpackage

// File: rtl/decode_queue_rv_decoder.sv
// Purely combinational RV32I(+M) instruction decoder: instr + pc -> uop_t.
// Unrecognised encodings yield a trap-only uop (illegal=1, ctl=31, no side effects).
module rv_decoder
    import decode_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]         i_instr,
    input  logic [UOP_XLEN-1:0] i_pc,
    output uop_t                o_uop_c
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_ill;
    uop_t        w_uop;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        w_uop     = '0;
        w_ill     = 1'b0;
        w_uop.pc  = i_pc;
        w_uop.rs1 = i_instr[19:15];
        w_uop.rs2 = i_instr[24:20];
        w_uop.rd  = i_instr[11:7];
        case (w_opcode)
            OPC_LUI: begin
                w_uop.ctl = CTL_LUI; w_uop.imm = w_imm_u;
                w_uop.src_imm = 1'b1; w_uop.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_uop.ctl = CTL_ADD; w_uop.imm = w_imm_u;
                w_uop.src_imm = 1'b1; w_uop.src_pc = 1'b1; w_uop.reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_uop.ctl = CTL_ADD; w_uop.imm = w_imm_j;
                w_uop.src_imm = 1'b1; w_uop.src_pc = 1'b1;
                w_uop.jump = 1'b1; w_uop.link = 1'b1; w_uop.reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_ill = (w_f3 != 3'b000);
                w_uop.ctl = CTL_ADD; w_uop.imm = w_imm_i; w_uop.read_rs1 = 1'b1;
                w_uop.src_imm = 1'b1; w_uop.jump = 1'b1; w_uop.link = 1'b1; w_uop.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_uop.imm = w_imm_b; w_uop.read_rs1 = 1'b1; w_uop.read_rs2 = 1'b1;
                w_uop.src_pc = 1'b1; w_uop.branch = 1'b1;
                case (w_f3)
                    3'b000:  w_uop.ctl = CTL_BEQ;
                    3'b001:  w_uop.ctl = CTL_BNE;
                    3'b100:  w_uop.ctl = CTL_BLT;
                    3'b101:  w_uop.ctl = CTL_BGE;
                    3'b110:  w_uop.ctl = CTL_BLTU;
                    3'b111:  w_uop.ctl = CTL_BGEU;
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                w_uop.ctl = CTL_ADD; w_uop.imm = w_imm_i; w_uop.read_rs1 = 1'b1;
                w_uop.src_imm = 1'b1; w_uop.mem_read = 1'b1; w_uop.reg_write = 1'b1;
                w_uop.mem_size = w_f3[1:0]; w_uop.mem_unsigned = w_f3[2];
            end
            OPC_STORE: begin
                w_ill = w_f3[2] || (w_f3[1:0] == 2'b11);
                w_uop.ctl = CTL_ADD; w_uop.imm = w_imm_s; w_uop.read_rs1 = 1'b1;
                w_uop.read_rs2 = 1'b1; w_uop.src_imm = 1'b1; w_uop.mem_write = 1'b1;
                w_uop.mem_size = w_f3[1:0];
            end
            OPC_OPIMM: begin
                w_uop.imm = w_imm_i; w_uop.read_rs1 = 1'b1;
                w_uop.src_imm = 1'b1; w_uop.reg_write = 1'b1;
                case (w_f3)
                    3'b000:  w_uop.ctl = CTL_ADD;
                    3'b010:  w_uop.ctl = CTL_SLT;
                    3'b011:  w_uop.ctl = CTL_SLTU;
                    3'b100:  w_uop.ctl = CTL_XOR;
                    3'b110:  w_uop.ctl = CTL_OR;
                    3'b111:  w_uop.ctl = CTL_AND;
                    3'b001: begin
                        w_uop.ctl = CTL_SLL; w_ill = (w_f7 != 7'b0000000);
                    end
                    default: begin
                        w_uop.ctl = (w_f7 == 7'b0100000) ? CTL_SRA : CTL_SRL;
                        w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                w_uop.read_rs1 = 1'b1; w_uop.read_rs2 = 1'b1; w_uop.reg_write = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_uop.ctl = CTL_ADD;
                        3'b001:  w_uop.ctl = CTL_SLL;
                        3'b010:  w_uop.ctl = CTL_SLT;
                        3'b011:  w_uop.ctl = CTL_SLTU;
                        3'b100:  w_uop.ctl = CTL_XOR;
                        3'b101:  w_uop.ctl = CTL_SRL;
                        3'b110:  w_uop.ctl = CTL_OR;
                        default: w_uop.ctl = CTL_AND;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_uop.ctl = CTL_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_uop.ctl = CTL_SRA;
                end else if (w_f7 == 7'b0000001 && EN_M) begin
                    w_uop.ctl = CTL_MUL | {2'b00, w_f3};
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_uop.rd == 5'd0) w_uop.reg_write = 1'b0;
        // Trap-only uop keeps pc and register fields for the downstream handler.
        if (w_ill) begin
            w_uop.imm          = '0;
            w_uop.read_rs1     = 1'b0;
            w_uop.read_rs2     = 1'b0;
            w_uop.src_imm      = 1'b0;
            w_uop.src_pc       = 1'b0;
            w_uop.reg_write    = 1'b0;
            w_uop.mem_read     = 1'b0;
            w_uop.mem_write    = 1'b0;
            w_uop.mem_size     = 2'b00;
            w_uop.mem_unsigned = 1'b0;
            w_uop.branch       = 1'b0;
            w_uop.jump         = 1'b0;
            w_uop.link         = 1'b0;
            w_uop.ctl          = CTL_ZERO;
            w_uop.illegal      = 1'b1;
        end
    end

    assign o_uop_c = w_uop;

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry output queue between fetch and issue.
// All handshake outputs come from registers; no fetch-to-issue combinational path.
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter bit          EN_M  = 1'b1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$bits(uop_t)-1:0] out_uop,
    output logic [CNT_W-1:0]        count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    uop_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid, r_in_ready;
    logic             w_push, w_pop;
    logic [CNT_W-1:0] w_cnt_nxt;
    uop_t             w_uop;

    rv_decoder #(.EN_M(EN_M)) u_dec (
        .i_instr (in_instr),
        .i_pc    (UOP_XLEN'(in_pc)),
        .o_uop_c (w_uop)
    );

    assign w_push    = in_valid & r_in_ready & ~flush;
    assign w_pop     = r_out_valid & out_ready & ~flush;
    assign w_cnt_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Queue state; flush zeroes occupancy and pointers but leaves storage as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_uop;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_cnt_nxt;
            r_out_valid <= (w_cnt_nxt != '0);
            r_in_ready  <= (w_cnt_nxt != CNT_W'(DEPTH));
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign out_uop   = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: scoreboard of expected uops, compared at the queue head.
// A second instance with EN_M=0 sees identical stimulus and must trap M encodings.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic                    clk, rst, in_valid, flush, out_ready;
    logic [31:0]             in_instr, in_pc;
    logic                    in_ready, out_valid, in_ready_nm, out_valid_nm;
    logic [$bits(uop_t)-1:0] out_uop, out_uop_nm;
    logic [CNT_W-1:0]        count, count_nm;

    uop_t sb0[$];
    uop_t sb1[$];
    int   mcnt;
    int   n_chk;
    int   n_err;

    decode_queue #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_uop(out_uop), .count(count)
    );

    decode_queue #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b0), .CNT_W(CNT_W)) u_dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nm),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_nm),
        .out_ready(out_ready), .out_uop(out_uop_nm), .count(count_nm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic uop_t base(input logic [31:0] ins, input logic [31:0] pc);
        uop_t u;
        u     = '0;
        u.pc  = pc;
        u.rs1 = ins[19:15];
        u.rs2 = ins[24:20];
        u.rd  = ins[11:7];
        return u;
    endfunction

    function automatic uop_t mk_ill(input logic [31:0] ins, input logic [31:0] pc);
        uop_t u;
        u         = base(ins, pc);
        u.ctl     = 5'd31;
        u.illegal = 1'b1;
        return u;
    endfunction

    function automatic uop_t mk_addi(input logic [11:0] k, input logic [31:0] pc);
        uop_t u;
        u           = base({k, 20'h00093}, pc);
        u.ctl       = 5'd2;
        u.imm       = {20'h0, k};
        u.read_rs1  = 1'b1;
        u.src_imm   = 1'b1;
        u.reg_write = 1'b1;
        return u;
    endfunction

    // One clock of stimulus: check head/handshake against the model, then advance the model.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input uop_t e0, input uop_t e1, input logic ordy, input logic fl,
                       input string tag);
        logic push, pop;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(mcnt != DEPTH));
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(mcnt != 0));
        chk({tag, ".count"}, 128'(count), 128'(mcnt));
        chk({tag, ".count_nm"}, 128'(count_nm), 128'(mcnt));
        if (mcnt != 0) begin
            chk({tag, ".uop"}, 128'(out_uop), 128'(sb0[0]));
            chk({tag, ".uop_nm"}, 128'(out_uop_nm), 128'(sb1[0]));
        end
        push = v && (mcnt != DEPTH) && !fl;
        pop  = ordy && (mcnt != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            sb0.delete();
            sb1.delete();
            mcnt = 0;
        end else begin
            if (pop) begin
                void'(sb0.pop_front());
                void'(sb1.pop_front());
                mcnt--;
            end
            if (push) begin
                sb0.push_back(e0);
                sb1.push_back(e1);
                mcnt++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        uop_t e, en, z;
        n_chk = 0; n_err = 0; mcnt = 0;
        z = '0;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.count", 128'(count), 128'(0));
        chk("rst.out_valid", 128'(out_valid), 128'(0));
        chk("rst.in_ready", 128'(in_ready), 128'(1));
        chk("rst.uop", 128'(out_uop), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single push, then pop.
        e = mk_addi(12'd5, 32'h100);
        cyc(1'b1, 32'h00500093, 32'h100, e, e, 1'b0, 1'b0, "addi");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "addi_pop");

        // Streaming mix with simultaneous push and pop.
        e = base(32'h00208463, 32'h104);
        e.ctl = 5'd24; e.imm = 32'd8; e.read_rs1 = 1'b1; e.read_rs2 = 1'b1;
        e.src_pc = 1'b1; e.branch = 1'b1;
        cyc(1'b1, 32'h00208463, 32'h104, e, e, 1'b1, 1'b0, "beq");

        e = base(32'h022081B3, 32'h108);
        e.ctl = 5'd16; e.read_rs1 = 1'b1; e.read_rs2 = 1'b1; e.reg_write = 1'b1;
        en = mk_ill(32'h022081B3, 32'h108);
        cyc(1'b1, 32'h022081B3, 32'h108, e, en, 1'b1, 1'b0, "mul");

        e = base(32'h123452B7, 32'h10C);
        e.ctl = 5'd10; e.imm = 32'h12345000; e.src_imm = 1'b1; e.reg_write = 1'b1;
        cyc(1'b1, 32'h123452B7, 32'h10C, e, e, 1'b1, 1'b0, "lui");

        e = base(32'h0020A623, 32'h110);
        e.ctl = 5'd2; e.imm = 32'd12; e.read_rs1 = 1'b1; e.read_rs2 = 1'b1;
        e.src_imm = 1'b1; e.mem_write = 1'b1; e.mem_size = 2'd2;
        cyc(1'b1, 32'h0020A623, 32'h110, e, e, 1'b1, 1'b0, "sw");

        e = base(32'hFFF0C203, 32'h114);
        e.ctl = 5'd2; e.imm = 32'hFFFFFFFF; e.read_rs1 = 1'b1; e.src_imm = 1'b1;
        e.mem_read = 1'b1; e.reg_write = 1'b1; e.mem_unsigned = 1'b1;
        cyc(1'b1, 32'hFFF0C203, 32'h114, e, e, 1'b1, 1'b0, "lbu");

        e = base(32'h010000EF, 32'h118);
        e.ctl = 5'd2; e.imm = 32'd16; e.src_imm = 1'b1; e.src_pc = 1'b1;
        e.jump = 1'b1; e.link = 1'b1; e.reg_write = 1'b1;
        cyc(1'b1, 32'h010000EF, 32'h118, e, e, 1'b1, 1'b0, "jal");

        e = base(32'h407302B3, 32'h11C);
        e.ctl = 5'd6; e.read_rs1 = 1'b1; e.read_rs2 = 1'b1; e.reg_write = 1'b1;
        cyc(1'b1, 32'h407302B3, 32'h11C, e, e, 1'b1, 1'b0, "sub");

        e = base(32'h4030D093, 32'h120);
        e.ctl = 5'd15; e.imm = 32'h403; e.read_rs1 = 1'b1; e.src_imm = 1'b1; e.reg_write = 1'b1;
        cyc(1'b1, 32'h4030D093, 32'h120, e, e, 1'b1, 1'b0, "srai");

        e = mk_ill(32'hFFFFFFFF, 32'h124);
        cyc(1'b1, 32'hFFFFFFFF, 32'h124, e, e, 1'b1, 1'b0, "illegal");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "drain");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "empty");

        // Backpressure: fill to DEPTH, third word held until a slot frees.
        cyc(1'b1, 32'h00100093, 32'h200, mk_addi(12'd1, 32'h200), mk_addi(12'd1, 32'h200), 1'b0, 1'b0, "bp_a");
        cyc(1'b1, 32'h00200093, 32'h204, mk_addi(12'd2, 32'h204), mk_addi(12'd2, 32'h204), 1'b0, 1'b0, "bp_b");
        cyc(1'b1, 32'h00300093, 32'h208, mk_addi(12'd3, 32'h208), mk_addi(12'd3, 32'h208), 1'b0, 1'b0, "bp_c_held");
        cyc(1'b1, 32'h00300093, 32'h208, mk_addi(12'd3, 32'h208), mk_addi(12'd3, 32'h208), 1'b1, 1'b0, "full_pop");
        cyc(1'b1, 32'h00300093, 32'h208, mk_addi(12'd3, 32'h208), mk_addi(12'd3, 32'h208), 1'b1, 1'b0, "bp_c_in");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "bp_drain");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b0, 1'b0, "bp_empty");

        // Flush at full and with a same-cycle push; flushed words must never surface.
        cyc(1'b1, 32'h00400093, 32'h300, mk_addi(12'd4, 32'h300), mk_addi(12'd4, 32'h300), 1'b0, 1'b0, "fl_a");
        cyc(1'b1, 32'h00500093, 32'h304, mk_addi(12'd5, 32'h304), mk_addi(12'd5, 32'h304), 1'b0, 1'b0, "fl_b");
        cyc(1'b1, 32'h00600093, 32'h308, mk_addi(12'd6, 32'h308), mk_addi(12'd6, 32'h308), 1'b1, 1'b1, "flush_full");
        cyc(1'b1, 32'h00700093, 32'h30C, mk_addi(12'd7, 32'h30C), mk_addi(12'd7, 32'h30C), 1'b0, 1'b0, "fl_c");
        cyc(1'b1, 32'h00800093, 32'h310, mk_addi(12'd8, 32'h310), mk_addi(12'd8, 32'h310), 1'b1, 1'b1, "flush_push");
        cyc(1'b1, 32'h00900093, 32'h314, mk_addi(12'd9, 32'h314), mk_addi(12'd9, 32'h314), 1'b0, 1'b0, "post_flush");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "post_flush_pop");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b0, 1'b0, "post_flush_empty");

        // Asynchronous reset with two entries queued.
        cyc(1'b1, 32'h00A00093, 32'h400, mk_addi(12'd10, 32'h400), mk_addi(12'd10, 32'h400), 1'b0, 1'b0, "ar_a");
        cyc(1'b1, 32'h00B00093, 32'h404, mk_addi(12'd11, 32'h404), mk_addi(12'd11, 32'h404), 1'b0, 1'b0, "ar_b");
        in_valid = 1'b0;
        chk("ar.pre_valid", 128'(out_valid), 128'(mcnt != 0));
        rst = 1'b1;
        #1;
        chk("ar.out_valid", 128'(out_valid), 128'(0));
        chk("ar.count", 128'(count), 128'(0));
        chk("ar.in_ready", 128'(in_ready), 128'(1));
        chk("ar.uop", 128'(out_uop), 128'(0));
        sb0.delete();
        sb1.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, 32'h00C00093, 32'h500, mk_addi(12'd12, 32'h500), mk_addi(12'd12, 32'h500), 1'b0, 1'b0, "ar_after");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b1, 1'b0, "ar_after_pop");
        cyc(1'b0, 32'h0, 32'h0, z, z, 1'b0, 1'b0, "final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
